adder_tree_loader: RTL and testbench
====================================

Name: adder_tree_loader

Overview:
- Sequential front-end that feeds the 8-operand, 7-bit combinational adder tree.
- Accepts operands one per handshake over a narrow 7-bit bus and drives all eight tree operand buses plus the tree carry-in.
- Waits a programmable settle time for the combinational tree, then registers the tree's sum and carry-out.
- Presents the registered result downstream with a valid/ready handshake.

Parameters:
- WIDTH, 7: operand/sum width; must equal the tree width (7).
- N_OPS, 8: operands per frame; fixed at 8 to match tree inputs a..h.
- SETTLE_CYCLES, 2: cycles the tree inputs are held stable before the result is sampled; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream operand word valid.
- in_ready  out  1  loader can accept an operand this cycle.
- in_data  in  7  operand word; index 0 maps to a, index 7 maps to h.
- in_ci  in  1  frame carry-in; sampled only with operand index 0.
- op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h  out  7 each  registered operands to tree inputs a..h.
- tree_ci  out  1  registered carry-in to tree ci.
- tree_s  in  7  tree sum output s.
- tree_co  in  1  tree carry output co.
- res_sum  out  7  registered frame sum.
- res_co  out  1  registered frame carry-out.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- busy  out  1  high in any state other than LOAD with idx=0.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=LOAD, idx=0, settle counter=0.
  - op_a..op_h=0, tree_ci=0, res_sum=0, res_co=0, res_valid=0, busy=0.
  - Reset mid-frame discards all partial operands; no result is produced for that frame.
  - in_ready is 1 in the first cycle after reset.
- State LOAD:
  - in_ready=1.
  - On in_valid&in_ready, in_data is written to the operand register selected by idx, and idx increments.
  - When idx=0, in_ci is also captured into tree_ci. in_ci is ignored at all other indices.
  - Accepting idx=7 moves the FSM to SETTLE with the counter set to SETTLE_CYCLES-1 and idx wrapping to 0.
  - in_valid=0 stalls the load; nothing changes.
- State SETTLE:
  - in_ready=0 and operand registers hold.
  - The counter decrements each cycle.
  - In the cycle the counter is 0, tree_s and tree_co are captured into res_sum and res_co, res_valid is set to 1, and the FSM moves to HOLD.
  - Latency: the result is visible SETTLE_CYCLES+1 cycles after the edge that accepts operand 7.
- State HOLD:
  - res_valid=1 and in_ready=0.
  - res_sum and res_co are stable until accepted.
  - On res_ready=1, res_valid clears on the next edge and the FSM returns to LOAD.
  - No operand is accepted in the same cycle as the result handshake; in_ready rises one cycle later.
- Operand registers keep their last frame's values until overwritten, so tree outputs are not glitch-sensitive between frames.
- Arithmetic: the loader performs none. Results are exactly the tree outputs: sum modulo 128 on res_sum, and the tree's final-stage carry on res_co.
- res_ready asserted outside HOLD has no effect.
- in_valid asserted outside LOAD is ignored; the word is not consumed.

Test Plan:
- Reset then load 1,2,3,4,5,6,7,8 with ci=0, SETTLE_CYCLES=2, res_ready=1 -> res_valid rises 3 cycles after the 8th accept; res_sum=36, res_co=0; in_ready returns 1 cycle after the handshake.
- Load a=127, the other seven operands 0, ci=1 -> res_sum=0, res_co=1.
- Load eight words of 16 with ci=0 -> res_sum=0 (128 mod 128); res_co equals tree_co as sampled.
- Gaps in in_valid between every word, with res_ready held 0 for 5 cycles -> operands land on the correct a..h; result stable for 5 cycles; in_ready=0 throughout HOLD; in_valid during HOLD is not consumed.
- Assert rst after 4 operands are accepted, then load a full frame of 10s with ci=1 -> no result for the aborted frame; new result res_sum=81 (80+1), res_co=0.
- Vary in_ci on indices 1..7 with ci=0 at index 0, operands all 1 -> tree_ci=0; res_sum=8.

Source files
------------

// File: rtl/adder_tree_loader.sv
// Sequential loader for the 8-operand adder tree: serial operand capture,
// settle wait, registered result with a valid/ready handshake.
module adder_tree_loader #(
    parameter int WIDTH         = 7,
    parameter int N_OPS         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_ci,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] op_c,
    output logic [WIDTH-1:0] op_d,
    output logic [WIDTH-1:0] op_e,
    output logic [WIDTH-1:0] op_f,
    output logic [WIDTH-1:0] op_g,
    output logic [WIDTH-1:0] op_h,
    output logic             tree_ci,
    input  logic [WIDTH-1:0] tree_s,
    input  logic             tree_co,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_co,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] IDX_LAST = 3'(N_OPS - 1);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic       accept;

    assign in_ready = (state == LOAD);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != LOAD) || (idx != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            idx       <= 3'd0;
            cnt       <= 4'd0;
            op_a      <= '0;
            op_b      <= '0;
            op_c      <= '0;
            op_d      <= '0;
            op_e      <= '0;
            op_f      <= '0;
            op_g      <= '0;
            op_h      <= '0;
            tree_ci   <= 1'b0;
            res_sum   <= '0;
            res_co    <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (accept) begin
                        case (idx)
                            3'd0: op_a <= in_data;
                            3'd1: op_b <= in_data;
                            3'd2: op_c <= in_data;
                            3'd3: op_d <= in_data;
                            3'd4: op_e <= in_data;
                            3'd5: op_f <= in_data;
                            3'd6: op_g <= in_data;
                            3'd7: op_h <= in_data;
                        endcase
                        // carry-in belongs to the frame, taken with operand a only
                        if (idx == 3'd0)
                            tree_ci <= in_ci;
                        if (idx == IDX_LAST) begin
                            idx   <= 3'd0;
                            cnt   <= CNT_INIT;
                            state <= SETTLE;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == 4'd0) begin
                        res_sum   <= tree_s;
                        res_co    <= tree_co;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_tree_loader.sv
// Bench for adder_tree_loader: behavioural adder tree, scoreboard of frame
// results, latency/handshake/reset checks.
module tb_adder_tree_loader;

    localparam int SETTLE = 2;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_data;
    logic       in_ci;
    logic [6:0] op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h;
    logic       tree_ci;
    logic [6:0] tree_s;
    logic       tree_co;
    logic [6:0] res_sum;
    logic       res_co;
    logic       res_valid;
    logic       res_ready;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb[$];

    adder_tree_loader #(
        .WIDTH(7),
        .N_OPS(8),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_ci(in_ci),
        .op_a(op_a),
        .op_b(op_b),
        .op_c(op_c),
        .op_d(op_d),
        .op_e(op_e),
        .op_f(op_f),
        .op_g(op_g),
        .op_h(op_h),
        .tree_ci(tree_ci),
        .tree_s(tree_s),
        .tree_co(tree_co),
        .res_sum(res_sum),
        .res_co(res_co),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural 8-operand tree: co is set when the total overflows 7 bits
    logic [9:0] ttot;
    always_comb begin
        ttot = 10'(op_a) + 10'(op_b) + 10'(op_c) + 10'(op_d)
             + 10'(op_e) + 10'(op_f) + 10'(op_g) + 10'(op_h)
             + 10'(tree_ci);
        tree_s  = ttot[6:0];
        tree_co = (ttot >= 10'd128);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [6:0] d, input logic ci,
                             input int gap);
        int b;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = d;
        in_ci    = ci;
        b = 0;
        while (!in_ready && b < 50) begin
            tick();
            b++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_frame(input logic [6:0] ops[8], input logic ci,
                              input int gap);
        int total;
        logic [6:0] got[8];
        total = int'(ci);
        for (int i = 0; i < 8; i++) begin
            total += int'(ops[i]);
            send_word(ops[i], (i == 0) ? ci : logic'(i[0]), gap);
            if (i == 0) check("busy_loading", 32'(busy), 32'd1);
        end
        sb.push_back({(total >= 128), 7'(total)});
        got = '{op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h};
        for (int i = 0; i < 8; i++)
            check($sformatf("op%0d", i), 32'(got[i]), 32'(ops[i]));
        check("tree_ci", 32'(tree_ci), 32'(ci));
        check("in_ready_settle", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_result();
        int cyc;
        cyc = 1;
        while (!res_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(SETTLE + 1));
    endtask

    task automatic take_result(input int stall, input bit poke,
                               input logic [6:0] exp_a);
        logic [7:0] first;
        logic [7:0] exp;
        first = {res_co, res_sum};
        for (int k = 0; k < stall; k++) begin
            if (poke) begin
                in_valid = 1'b1;
                in_data  = 7'd55;
                in_ci    = 1'b1;
            end
            tick();
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_stable", 32'({res_co, res_sum}), 32'(first));
        end
        in_valid = 1'b0;
        if (poke) check("hold_no_consume", 32'(op_a), 32'(exp_a));
        check("hold_busy", 32'(busy), 32'd1);
        res_ready = 1'b1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            exp = sb.pop_front();
            check("result", 32'({res_co, res_sum}), 32'(exp));
        end
        tick();
        res_ready = 1'b0;
        check("valid_cleared", 32'(res_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [6:0] ops[8];
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ci     = 1'b0;
        res_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_sum", 32'({res_co, res_sum}), 32'd0);
        check("rst_ops", 32'({op_a, op_h, tree_ci}), 32'd0);

        // 1..8, ready held high across the whole frame
        res_ready = 1'b1;
        ops = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8};
        load_frame(ops, 1'b0, 0);
        check("settle_no_result", 32'(res_valid), 32'd0);
        wait_result();
        check("sum36", 32'(res_sum), 32'd36);
        take_result(0, 1'b0, ops[0]);

        ops = '{7'd127, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        load_frame(ops, 1'b1, 0);
        wait_result();
        take_result(0, 1'b0, ops[0]);

        ops = '{default: 7'd16};
        load_frame(ops, 1'b0, 0);
        wait_result();
        take_result(1, 1'b0, ops[0]);

        // gaps between words, stalled result, in_valid during HOLD
        ops = '{7'd3, 7'd9, 7'd27, 7'd81, 7'd15, 7'd45, 7'd100, 7'd7};
        load_frame(ops, 1'b0, 2);
        wait_result();
        take_result(5, 1'b1, ops[0]);

        // abort after four operands
        for (int i = 0; i < 4; i++) send_word(7'd33, 1'b1, 0);
        check("partial_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_op_a", 32'(op_a), 32'd0);
        check("abort_ci", 32'(tree_ci), 32'd0);
        repeat (SETTLE + 3) tick();
        check("abort_no_result", 32'(res_valid), 32'd0);
        ops = '{default: 7'd10};
        load_frame(ops, 1'b1, 0);
        wait_result();
        check("sum81", 32'(res_sum), 32'd81);
        take_result(0, 1'b0, ops[0]);

        // carry-in toggled on indices 1..7 must be ignored
        ops = '{default: 7'd1};
        load_frame(ops, 1'b0, 1);
        wait_result();
        check("sum8", 32'(res_sum), 32'd8);
        take_result(2, 1'b0, ops[0]);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
